// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - per-scanline sprite compositor with double-buffered line store
module sprite_line_engine #(
  parameter int NUM_SPRITES = 64,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int H_RES       = 640,
  parameter int COLOR_BITS  = 4,
  parameter int COORD_BITS  = 10,
  parameter int ID_BITS     = 6,
  localparam int IDX_BITS   = $clog2(NUM_SPRITES),
  localparam int ROW_BITS   = $clog2(SPRITE_H),
  localparam int COL_BITS   = $clog2(SPRITE_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  attr_we,
  input  logic [IDX_BITS-1:0]   attr_index,
  input  logic [COORD_BITS-1:0] attr_x,
  input  logic [COORD_BITS-1:0] attr_y,
  input  logic [ID_BITS-1:0]    attr_id,
  input  logic                  attr_flip,
  input  logic                  line_start,
  input  logic [COORD_BITS-1:0] line_y,
  input  logic [COLOR_BITS-1:0] bg_color,
  output logic [ID_BITS-1:0]    rom_id,
  output logic [ROW_BITS-1:0]   rom_row,
  output logic [COL_BITS-1:0]   rom_col,
  input  logic [COLOR_BITS-1:0] rom_pixel,
  input  logic [COORD_BITS-1:0] rd_x,
  output logic [COLOR_BITS-1:0] rd_color,
  output logic                  busy,
  output logic                  collision,
  output logic                  overrun,
  input  logic                  flags_clr
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_CHECK, S_DRAW} state_t;

  localparam int LB_BITS = H_RES * COLOR_BITS;

  logic [COORD_BITS-1:0] tx_mem   [NUM_SPRITES];
  logic [COORD_BITS-1:0] ty_mem   [NUM_SPRITES];
  logic [ID_BITS-1:0]    tid_mem  [NUM_SPRITES];
  logic                  tflip_mem[NUM_SPRITES];

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [COL_BITS:0]     p_q, p_d;
  logic [COORD_BITS-1:0] clr_q, clr_d;
  logic [COORD_BITS-1:0] line_y_q, line_y_d;
  logic [COLOR_BITS-1:0] bg_q, bg_d;
  logic                  sel_q, sel_d;
  logic                  collision_q, collision_d;
  logic                  overrun_q, overrun_d;
  logic [ID_BITS-1:0]    rom_id_q, rom_id_d;
  logic [ROW_BITS-1:0]   rom_row_q, rom_row_d;
  logic [COL_BITS-1:0]   rom_col_q, rom_col_d;
  logic [COLOR_BITS-1:0] rd_color_q, rd_color_d;
  logic [COORD_BITS-1:0] ent_x_q, ent_x_d;
  logic [COORD_BITS-1:0] ent_y_q, ent_y_d;
  logic [ID_BITS-1:0]    ent_id_q, ent_id_d;
  logic                  ent_flip_q, ent_flip_d;
  logic [LB_BITS-1:0]    lb0_q, lb0_d;
  logic [LB_BITS-1:0]    lb1_q, lb1_d;
  logic [H_RES-1:0]      mask_q, mask_d;

  logic [COORD_BITS:0]   dy, draw_col;
  logic [COL_BITS:0]     p_prev, p_next;
  logic                  hit, advance, wr_en, wr_mask, coll_set, ovr_set;
  logic [COORD_BITS-1:0] wr_col;
  logic [COLOR_BITS-1:0] wr_data;
  logic [LB_BITS-1:0]    disp;

  // Attribute RAM: registered read in FETCH naturally returns pre-write data.
  always_ff @(posedge clk) begin
    if (attr_we) begin
      tx_mem[attr_index]    <= attr_x;
      ty_mem[attr_index]    <= attr_y;
      tid_mem[attr_index]   <= attr_id;
      tflip_mem[attr_index] <= attr_flip;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    p_d         = p_q;
    clr_d       = clr_q;
    line_y_d    = line_y_q;
    bg_d        = bg_q;
    sel_d       = sel_q;
    rom_id_d    = rom_id_q;
    rom_row_d   = rom_row_q;
    rom_col_d   = rom_col_q;
    ent_x_d     = ent_x_q;
    ent_y_d     = ent_y_q;
    ent_id_d    = ent_id_q;
    ent_flip_d  = ent_flip_q;
    lb0_d       = lb0_q;
    lb1_d       = lb1_q;
    mask_d      = mask_q;
    wr_en       = 1'b0;
    wr_col      = '0;
    wr_data     = '0;
    wr_mask     = 1'b0;
    coll_set    = 1'b0;
    ovr_set     = 1'b0;
    advance     = 1'b0;

    dy       = {1'b0, line_y_q} - {1'b0, ent_y_q};
    hit      = (ent_id_q != '0) && (line_y_q >= ent_y_q) &&
               (dy < (COORD_BITS+1)'(SPRITE_H));
    p_prev   = p_q - (COL_BITS+1)'(1);
    p_next   = p_q + (COL_BITS+1)'(1);
    // Carry bit keeps sprites hanging off the right edge from wrapping to column 0.
    draw_col = {1'b0, ent_x_q} + (COORD_BITS+1)'(p_prev);

    case (state_q)
      S_IDLE: ;
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_col  = clr_q;
        wr_data = bg_q;
        if (clr_q == COORD_BITS'(H_RES-1)) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else begin
          clr_d = clr_q + COORD_BITS'(1);
        end
      end
      S_FETCH: begin
        ent_x_d    = tx_mem[idx_q];
        ent_y_d    = ty_mem[idx_q];
        ent_id_d   = tid_mem[idx_q];
        ent_flip_d = tflip_mem[idx_q];
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (hit) begin
          state_d   = S_DRAW;
          p_d       = '0;
          rom_id_d  = ent_id_q;
          rom_row_d = dy[ROW_BITS-1:0];
          rom_col_d = ent_flip_q ? COL_BITS'(SPRITE_W-1) : '0;
        end else begin
          advance = 1'b1;
        end
      end
      S_DRAW: begin
        // p_q counts issue cycles; the pixel for p_q-1 is on rom_pixel now.
        if ((p_q != '0) && (rom_pixel != '0) &&
            (draw_col < (COORD_BITS+1)'(H_RES))) begin
          wr_en    = 1'b1;
          wr_col   = draw_col[COORD_BITS-1:0];
          wr_data  = rom_pixel;
          wr_mask  = 1'b1;
          coll_set = mask_q[draw_col[COORD_BITS-1:0]];
        end
        if (p_q == (COL_BITS+1)'(SPRITE_W)) begin
          advance = 1'b1;
        end else begin
          p_d = p_next;
          if (p_next < (COL_BITS+1)'(SPRITE_W)) begin
            rom_col_d = ent_flip_q ? (COL_BITS'(SPRITE_W-1) - p_next[COL_BITS-1:0])
                                   : p_next[COL_BITS-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == IDX_BITS'(NUM_SPRITES-1)) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + IDX_BITS'(1);
        state_d = S_FETCH;
      end
    end

    // A new line always wins: abort whatever is in flight and restart clearing.
    if (line_start) begin
      ovr_set  = (state_q != S_IDLE);
      state_d  = S_CLEAR;
      clr_d    = '0;
      idx_d    = '0;
      line_y_d = line_y;
      bg_d     = bg_color;
      sel_d    = ~sel_q;
      wr_en    = 1'b0;
      coll_set = 1'b0;
    end

    if (wr_en) begin
      if (sel_q) lb1_d[int'(wr_col)*COLOR_BITS +: COLOR_BITS] = wr_data;
      else       lb0_d[int'(wr_col)*COLOR_BITS +: COLOR_BITS] = wr_data;
      mask_d[wr_col] = wr_mask;
    end

    collision_d = (collision_q & ~flags_clr) | coll_set;
    overrun_d   = (overrun_q & ~flags_clr) | ovr_set;

    disp       = sel_q ? lb0_q : lb1_q;
    rd_color_d = ({1'b0, rd_x} < (COORD_BITS+1)'(H_RES))
                 ? disp[int'(rd_x)*COLOR_BITS +: COLOR_BITS] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      p_q         <= '0;
      clr_q       <= '0;
      line_y_q    <= '0;
      bg_q        <= '0;
      sel_q       <= 1'b0;
      collision_q <= 1'b0;
      overrun_q   <= 1'b0;
      rom_id_q    <= '0;
      rom_row_q   <= '0;
      rom_col_q   <= '0;
      rd_color_q  <= '0;
      ent_x_q     <= '0;
      ent_y_q     <= '0;
      ent_id_q    <= '0;
      ent_flip_q  <= 1'b0;
      lb0_q       <= '0;
      lb1_q       <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      clr_q       <= clr_d;
      line_y_q    <= line_y_d;
      bg_q        <= bg_d;
      sel_q       <= sel_d;
      collision_q <= collision_d;
      overrun_q   <= overrun_d;
      rom_id_q    <= rom_id_d;
      rom_row_q   <= rom_row_d;
      rom_col_q   <= rom_col_d;
      rd_color_q  <= rd_color_d;
      ent_x_q     <= ent_x_d;
      ent_y_q     <= ent_y_d;
      ent_id_q    <= ent_id_d;
      ent_flip_q  <= ent_flip_d;
      lb0_q       <= lb0_d;
      lb1_q       <= lb1_d;
      mask_q      <= mask_d;
    end
  end

  assign rom_id    = rom_id_q;
  assign rom_row   = rom_row_q;
  assign rom_col   = rom_col_q;
  assign rd_color  = rd_color_q;
  assign busy      = (state_q != S_IDLE);
  assign collision = collision_q;
  assign overrun   = overrun_q;

endmodule
